// File: rtl/uart_cmd_loader_if.sv
// rtl/uart_cmd_loader_if.sv - receive-side and instruction-memory/control signals of the UART command loader
interface uart_cmd_loader_if #(
  parameter int NB_DATA = 8,
  parameter int NB_WORD = 32,
  parameter int NB_ADDR = 8
);
  logic               i_rx_done;
  logic [NB_DATA-1:0] i_rx_data;
  logic               i_signal_tick;
  logic               o_imem_wr_en;
  logic [NB_ADDR-1:0] o_imem_addr;
  logic [NB_WORD-1:0] o_imem_data;
  logic               o_run;
  logic               o_step;
  logic               o_load_done;
  logic               o_cmd_error;
  logic               o_busy;

  modport master (
    output i_rx_done, i_rx_data, i_signal_tick,
    input  o_imem_wr_en, o_imem_addr, o_imem_data, o_run, o_step,
           o_load_done, o_cmd_error, o_busy
  );

  modport slave (
    input  i_rx_done, i_rx_data, i_signal_tick,
    output o_imem_wr_en, o_imem_addr, o_imem_data, o_run, o_step,
           o_load_done, o_cmd_error, o_busy
  );
endinterface

// File: rtl/uart_cmd_loader.sv
// rtl/uart_cmd_loader.sv - UART byte-stream command decoder and instruction memory loader
module uart_cmd_loader #(
  parameter int NB_DATA   = 8,
  parameter int NB_WORD   = 32,
  parameter int NB_ADDR   = 8,
  parameter int N_TIMEOUT = 2048
) (
  input logic               i_clock,
  input logic               i_reset,
  uart_cmd_loader_if.slave  ldr_if
);
  localparam int N_BYTES = NB_WORD / NB_DATA;
  localparam int NB_BIDX = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam int NB_TMO  = $clog2(N_TIMEOUT);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_BYTE  = 2'd2;
  localparam logic [1:0] ST_WRITE = 2'd3;

  localparam logic [NB_DATA-1:0] OP_LOAD = NB_DATA'(8'h4C);
  localparam logic [NB_DATA-1:0] OP_CONT = NB_DATA'(8'h43);
  localparam logic [NB_DATA-1:0] OP_STOP = NB_DATA'(8'h58);
  localparam logic [NB_DATA-1:0] OP_STEP = NB_DATA'(8'h53);

  localparam logic [NB_TMO-1:0]  TMO_LAST  = NB_TMO'(N_TIMEOUT - 2);
  localparam logic [NB_BIDX-1:0] BIDX_LAST = NB_BIDX'(N_BYTES - 1);

  logic [1:0]         state_q, state_d;
  logic [NB_WORD-1:0] word_q, word_d;
  logic [NB_BIDX-1:0] bidx_q, bidx_d;
  logic [NB_ADDR-1:0] addr_q, addr_d;
  logic [NB_DATA-1:0] left_q, left_d;
  logic [NB_TMO-1:0]  tmo_q, tmo_d;
  logic               pend_q, pend_d;
  logic [NB_DATA-1:0] pend_data_q, pend_data_d;
  logic               run_q, run_d;
  logic               step_q, step_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               wr_q, wr_d;

  // A byte held over from the final WRITE cycle is consumed ahead of any new arrival.
  logic               in_valid;
  logic [NB_DATA-1:0] in_byte;
  logic [NB_WORD-1:0] word_shift;
  logic               timed_out;

  assign in_valid   = pend_q | ldr_if.i_rx_done;
  assign in_byte    = pend_q ? pend_data_q : ldr_if.i_rx_data;
  assign word_shift = {in_byte, word_q[NB_WORD-1:NB_DATA]};
  assign timed_out  = ldr_if.i_signal_tick && (tmo_q == TMO_LAST);

  // Next-state logic: command decode, word assembly, write sequencing and byte timeout.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    bidx_d      = bidx_q;
    addr_d      = addr_q;
    left_d      = left_q;
    tmo_d       = tmo_q;
    run_d       = run_q;
    step_d      = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    wr_d        = 1'b0;
    pend_d      = pend_q & ldr_if.i_rx_done;
    pend_data_d = (pend_q & ldr_if.i_rx_done) ? ldr_if.i_rx_data : pend_data_q;

    case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        if (in_valid) begin
          case (in_byte)
            OP_LOAD: begin
              if (run_q) err_d = 1'b1;
              else begin
                state_d = ST_COUNT;
                bidx_d  = '0;
              end
            end
            OP_CONT: run_d = 1'b1;
            OP_STOP: run_d = 1'b0;
            OP_STEP: begin
              if (run_q) err_d = 1'b1;
              else       step_d = 1'b1;
            end
            default: err_d = 1'b1;
          endcase
        end
      end

      ST_COUNT: begin
        if (in_valid) begin
          tmo_d = '0;
          if (in_byte == '0) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            left_d  = in_byte;
            addr_d  = '0;
            bidx_d  = '0;
            state_d = ST_BYTE;
          end
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (ldr_if.i_signal_tick) begin
          tmo_d = tmo_q + NB_TMO'(1);
        end
      end

      ST_BYTE: begin
        if (in_valid) begin
          tmo_d  = '0;
          word_d = word_shift;
          if (bidx_q == BIDX_LAST) begin
            bidx_d  = '0;
            wr_d    = 1'b1;
            done_d  = (left_q == NB_DATA'(1));
            state_d = ST_WRITE;
          end else begin
            bidx_d = bidx_q + NB_BIDX'(1);
          end
        end else if (timed_out) begin
          err_d   = 1'b1;
          bidx_d  = '0;
          state_d = ST_IDLE;
        end else if (ldr_if.i_signal_tick) begin
          tmo_d = tmo_q + NB_TMO'(1);
        end
      end

      default: begin
        tmo_d  = '0;
        addr_d = addr_q + NB_ADDR'(1);
        left_d = left_q - NB_DATA'(1);
        if (left_q == NB_DATA'(1)) begin
          state_d = ST_IDLE;
          if (in_valid) begin
            pend_d      = 1'b1;
            pend_data_d = in_byte;
          end
        end else begin
          state_d = ST_BYTE;
          if (in_valid) begin
            word_d = word_shift;
            bidx_d = NB_BIDX'(1);
          end
        end
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      word_q      <= '0;
      bidx_q      <= '0;
      addr_q      <= '0;
      left_q      <= '0;
      tmo_q       <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      run_q       <= 1'b0;
      step_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      wr_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      bidx_q      <= bidx_d;
      addr_q      <= addr_d;
      left_q      <= left_d;
      tmo_q       <= tmo_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      run_q       <= run_d;
      step_q      <= step_d;
      done_q      <= done_d;
      err_q       <= err_d;
      wr_q        <= wr_d;
    end
  end

  assign ldr_if.o_imem_wr_en = wr_q;
  assign ldr_if.o_imem_addr  = addr_q;
  assign ldr_if.o_imem_data  = word_q;
  assign ldr_if.o_run        = run_q;
  assign ldr_if.o_step       = step_q;
  assign ldr_if.o_load_done  = done_q;
  assign ldr_if.o_cmd_error  = err_q;
  assign ldr_if.o_busy       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_uart_cmd_loader.sv
// tb/tb_uart_cmd_loader.sv - self-checking bench for uart_cmd_loader with a byte-level reference model
module tb_uart_cmd_loader;
  localparam int N_TIMEOUT = 2048;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_cmd_loader_if #(.NB_DATA(8), .NB_WORD(32), .NB_ADDR(8)) bus ();

  uart_cmd_loader #(.NB_DATA(8), .NB_WORD(32), .NB_ADDR(8), .N_TIMEOUT(N_TIMEOUT)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .ldr_if  (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: frame progress tracked as a byte list and word counters.
  typedef enum {M_IDLE, M_COUNT, M_DATA} mode_t;
  mode_t      m_mode;
  logic [7:0] m_bytes[$];
  int         m_total, m_written, m_ticks;
  bit         m_run, m_wcycle, m_def, m_valid = 0;
  logic [7:0] m_def_b;
  logic       e_wr, e_step, e_done, e_err, e_run, e_busy;
  logic [7:0] e_addr;
  logic [31:0] e_data;

  task model_tick();
    if (bus.i_signal_tick) begin
      m_ticks++;
      if (m_ticks == N_TIMEOUT - 1) begin
        e_err  = 1'b1;
        m_mode = M_IDLE;
        m_bytes.delete();
      end
    end
  endtask

  always @(posedge clk) begin
    logic       have;
    logic [7:0] b;
    bit         wcyc;
    if (rst) begin
      m_valid = 1; m_mode = M_IDLE; m_run = 0; m_def = 0; m_wcycle = 0; m_ticks = 0;
      m_bytes.delete();
      e_wr = 0; e_addr = 0; e_data = 0; e_step = 0; e_done = 0; e_err = 0; e_run = 0; e_busy = 0;
    end else begin
      wcyc = m_wcycle; m_wcycle = 0; have = 0; b = 0;
      e_wr = 0; e_step = 0; e_done = 0; e_err = 0;
      if (m_def) begin
        have = 1; b = m_def_b; m_def = bus.i_rx_done; m_def_b = bus.i_rx_data;
      end else if (bus.i_rx_done) begin
        have = 1; b = bus.i_rx_data;
      end
      if (wcyc) begin
        m_ticks = 0;
        if (have) begin
          if (m_mode == M_DATA) m_bytes.push_back(b);
          else begin m_def = 1; m_def_b = b; end
        end
      end else begin
        case (m_mode)
          M_IDLE: if (have) begin
            if (b == 8'h4C) begin
              if (m_run) e_err = 1;
              else begin m_mode = M_COUNT; m_ticks = 0; end
            end else if (b == 8'h43) m_run = 1;
            else if (b == 8'h58) m_run = 0;
            else if (b == 8'h53) begin
              if (m_run) e_err = 1; else e_step = 1;
            end else e_err = 1;
          end
          M_COUNT: if (have) begin
            m_ticks = 0;
            if (b == 0) begin e_done = 1; m_mode = M_IDLE; end
            else begin m_total = b; m_written = 0; m_bytes.delete(); m_mode = M_DATA; end
          end else model_tick();
          default: if (have) begin
            m_ticks = 0;
            m_bytes.push_back(b);
            if (m_bytes.size() == 4) begin
              e_wr = 1; e_addr = 8'(m_written); e_data = 0;
              for (int i = 0; i < 4; i++) e_data = e_data | (32'(m_bytes[i]) << (8 * i));
              m_bytes.delete(); m_written++; m_wcycle = 1;
              if (m_written == m_total) begin e_done = 1; m_mode = M_IDLE; end
            end
          end else model_tick();
        endcase
      end
      e_run  = m_run;
      e_busy = (m_mode != M_IDLE) || e_wr;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("wr_en",     64'(bus.o_imem_wr_en), 64'(e_wr));
      chk("run",       64'(bus.o_run),        64'(e_run));
      chk("step",      64'(bus.o_step),       64'(e_step));
      chk("load_done", 64'(bus.o_load_done),  64'(e_done));
      chk("cmd_error", 64'(bus.o_cmd_error),  64'(e_err));
      chk("busy",      64'(bus.o_busy),       64'(e_busy));
      if (e_wr) begin
        chk("imem_addr", 64'(bus.o_imem_addr), 64'(e_addr));
        chk("imem_data", 64'(bus.o_imem_data), 64'(e_data));
      end
    end
  end

  // Observed-event logs used by the literal expectations.
  logic [7:0]  wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  int cnt_err, cnt_step, cnt_done, cnt_done_wr;
  always @(negedge clk) begin
    if (bus.o_imem_wr_en) begin
      wr_addr_log.push_back(bus.o_imem_addr);
      wr_data_log.push_back(bus.o_imem_data);
    end
    cnt_err     += int'(bus.o_cmd_error);
    cnt_step    += int'(bus.o_step);
    cnt_done    += int'(bus.o_load_done);
    cnt_done_wr += int'(bus.o_load_done & bus.o_imem_wr_en);
  end

  task automatic clear_logs();
    wr_addr_log.delete(); wr_data_log.delete();
    cnt_err = 0; cnt_step = 0; cnt_done = 0; cnt_done_wr = 0;
  endtask

  int tick_mode = 2;
  initial begin
    bus.i_signal_tick = 1'b0;
    forever begin
      @(negedge clk);
      case (tick_mode)
        0:       bus.i_signal_tick = 1'b0;
        1:       bus.i_signal_tick = 1'b1;
        default: bus.i_signal_tick = ($urandom_range(0, 3) == 0);
      endcase
    end
  end

  // Called at a falling edge; returns at a falling edge.
  task automatic send(input logic [7:0] b, input int gap);
    bus.i_rx_done = 1'b1;
    bus.i_rx_data = b;
    @(negedge clk);
    bus.i_rx_done = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_seq(input logic [7:0] s[$], input int gap);
    foreach (s[i]) send(s[i], gap);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int rg();
    return (($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] seq[$];

  initial begin
    rst = 1'b1;
    bus.i_rx_done = 1'b0;
    bus.i_rx_data = 8'h00;
    @(negedge clk);
    idle(2);
    rst = 1'b0;
    idle(10);
    chk("reset_ctrl", 64'({bus.o_imem_wr_en, bus.o_run, bus.o_step, bus.o_load_done,
                           bus.o_cmd_error, bus.o_busy}), 64'h0);
    chk("reset_addr", 64'(bus.o_imem_addr), 64'h0);
    chk("reset_data", 64'(bus.o_imem_data), 64'h0);

    clear_logs();
    seq = '{8'h4C, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_seq(seq, 2);
    idle(4);
    chk("load2_nwr",   64'(wr_addr_log.size()), 64'd2);
    chk("load2_a0",    64'(wr_addr_log[0]), 64'h0);
    chk("load2_d0",    64'(wr_data_log[0]), 64'h12345678);
    chk("load2_a1",    64'(wr_addr_log[1]), 64'h1);
    chk("load2_d1",    64'(wr_data_log[1]), 64'hDEADBEEF);
    chk("load2_dwr",   64'(cnt_done_wr), 64'd1);
    chk("load2_busy",  64'(bus.o_busy), 64'h0);

    clear_logs();
    send(8'h43, 2);
    chk("cont_run", 64'(bus.o_run), 64'h1);
    send(8'h53, 2);
    chk("step_run_err",  64'(cnt_err), 64'd1);
    chk("step_run_nstp", 64'(cnt_step), 64'd0);
    send(8'h58, 2);
    chk("stop_run", 64'(bus.o_run), 64'h0);
    bus.i_rx_done = 1'b1; bus.i_rx_data = 8'h53;
    @(negedge clk);
    bus.i_rx_done = 1'b0;
    chk("step_pulse", 64'(bus.o_step), 64'h1);
    idle(3);
    chk("step_count", 64'(cnt_step), 64'd1);

    clear_logs();
    send(8'h7A, 3);
    chk("bad_err",  64'(cnt_err), 64'd1);
    chk("bad_busy", 64'(bus.o_busy), 64'h0);
    send(8'h4C, 2); send(8'h00, 3);
    chk("zero_done", 64'(cnt_done), 64'd1);
    chk("zero_nwr",  64'(wr_addr_log.size()), 64'd0);

    clear_logs();
    tick_mode = 1;
    seq = '{8'h4C, 8'h01, 8'hAA, 8'hBB};
    send_seq(seq, 1);
    idle(N_TIMEOUT + 10);
    chk("tmo_err",  64'(cnt_err), 64'd1);
    chk("tmo_nwr",  64'(wr_addr_log.size()), 64'd0);
    chk("tmo_busy", 64'(bus.o_busy), 64'h0);
    tick_mode = 2;
    clear_logs();
    seq = '{8'h4C, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    send_seq(seq, 2);
    idle(3);
    chk("post_tmo_nwr", 64'(wr_addr_log.size()), 64'd1);
    chk("post_tmo_a0",  64'(wr_addr_log[0]), 64'h0);
    chk("post_tmo_d0",  64'(wr_data_log[0]), 64'h44332211);

    clear_logs();
    seq = '{8'h4C, 8'h02, 8'h11, 8'h22};
    send_seq(seq, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send(8'h33, 2); send(8'h44, 5);
    chk("rst_nwr", 64'(wr_addr_log.size()), 64'd0);
    seq = '{8'h4C, 8'h01, 8'h55, 8'h66, 8'h77, 8'h88};
    send_seq(seq, 2);
    idle(3);
    chk("rst_reload_nwr", 64'(wr_addr_log.size()), 64'd1);
    chk("rst_reload_a0",  64'(wr_addr_log[0]), 64'h0);
    chk("rst_reload_d0",  64'(wr_data_log[0]), 64'h88776655);

    clear_logs();
    seq = '{8'h4C, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h43};
    send_seq(seq, 0);
    idle(3);
    chk("b2b_nwr", 64'(wr_addr_log.size()), 64'd2);
    chk("b2b_d0",  64'(wr_data_log[0]), 64'h04030201);
    chk("b2b_d1",  64'(wr_data_log[1]), 64'h08070605);
    chk("b2b_run", 64'(bus.o_run), 64'h1);
    send(8'h58, 2);

    for (int k = 0; k < 400; k++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 35) begin
        int n;
        n = $urandom_range(0, 4);
        send(8'h4C, rg());
        send(8'(n), rg());
        for (int w = 0; w < 4 * n; w++) send(8'($urandom), rg());
      end else if (r < 50) send(8'h43, rg());
      else if (r < 65) send(8'h58, rg());
      else if (r < 80) send(8'h53, rg());
      else if (r < 90) send(8'($urandom), rg());
      else if (r < 94) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end else idle($urandom_range(1, 20));
    end
    idle(5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
